// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges in-order write-back with buffered long-latency
// results and tracks destinations with an outstanding long-latency write.
module wb_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wb_valid,
  input  logic [ADDR_W-1:0]    i_wb_rd,
  input  logic [DATA_W-1:0]    i_wb_data,
  output logic                 o_wb_stall,
  input  logic                 i_iss_valid,
  input  logic [ADDR_W-1:0]    i_iss_rd,
  input  logic                 i_llu_valid,
  input  logic [ADDR_W-1:0]    i_llu_rd,
  input  logic [DATA_W-1:0]    i_llu_data,
  output logic                 o_llu_ready,
  output logic                 o_rf_we,
  output logic [ADDR_W-1:0]    o_rf_waddr,
  output logic [DATA_W-1:0]    o_rf_wdata,
  output logic [2**ADDR_W-1:0] o_pending
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = $clog2(STARVE_MAX + 1);
  localparam int unsigned NumRegs = 2**ADDR_W;

  logic [ADDR_W-1:0]  fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    starve_q, starve_d;
  logic [NumRegs-1:0] pending_q, pending_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  logic              empty, full, starved;
  logic              fifo_win, pipe_win, push;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign starved   = (starve_q == CntW'(STARVE_MAX));
  assign head_rd   = fifo_rd_q[rd_ptr_q[PtrW-1:0]];
  assign head_data = fifo_data_q[rd_ptr_q[PtrW-1:0]];

  assign fifo_win    = !i_rst && !empty && (full || starved || !i_wb_valid);
  assign pipe_win    = !i_rst && i_wb_valid && !fifo_win;
  assign o_wb_stall  = i_wb_valid && fifo_win;
  assign o_llu_ready = !i_rst && !full;
  assign push        = i_llu_valid && o_llu_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)     wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
    if (fifo_win) rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_win || empty) begin
      starve_d = '0;
    end else if (pipe_win && !starved) begin
      starve_d = starve_q + {{(CntW-1){1'b0}}, 1'b1};
    end
  end

  // Clear before set so a same-cycle reissue of the popped destination stays pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_win)    pending_d[head_rd]  = 1'b0;
    if (i_iss_valid) pending_d[i_iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (fifo_win) begin
      rf_we_d    = (head_rd != '0);
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end else if (pipe_win) begin
      rf_we_d    = (i_wb_rd != '0);
      rf_waddr_d = i_wb_rd;
      rf_wdata_d = i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      pending_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q[PtrW-1:0]]   <= i_llu_rd;
      fifo_data_q[wr_ptr_q[PtrW-1:0]] <= i_llu_data;
    end
  end

  assign o_rf_we    = rf_we_q;
  assign o_rf_waddr = rf_waddr_q;
  assign o_rf_wdata = rf_wdata_q;
  assign o_pending  = pending_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// handshakes, pending bits and timed register-file writes; a monitor checks the writes.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_stall;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rd = '0;
  logic          llu_valid = 1'b0;
  logic [AW-1:0] llu_rd = '0;
  logic [DW-1:0] llu_data = '0;
  logic          llu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   pending;

  wb_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data), .o_wb_stall(wb_stall),
    .i_iss_valid(iss_valid), .i_iss_rd(iss_rd),
    .i_llu_valid(llu_valid), .i_llu_rd(llu_rd), .i_llu_data(llu_data),
    .o_llu_ready(llu_ready),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata), .o_pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    int            due;
  } ent_t;

  ent_t        mfifo[$];
  ent_t        exp_q[$];
  int          mstarve = 0;
  logic [31:0] mpend = '0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          last_stall = 1'b0;
  bit          last_llu_acc = 1'b0;
  bit          dut_stall = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: evaluate the model on the settled inputs, then advance past the edge.
  task automatic step();
    bit   p, f, fl, fw, pw;
    ent_t e;
    @(negedge clk);
    dut_stall = wb_stall;
    if (rst) begin
      check("stall_in_reset", wb_stall, 0);
      check("ready_in_reset", llu_ready, 0);
      mfifo.delete();
      mstarve = 0;
      mpend = '0;
      last_stall = 0;
      last_llu_acc = 0;
    end else begin
      p  = wb_valid;
      f  = (mfifo.size() > 0);
      fl = (mfifo.size() == DEPTH);
      fw = f && (fl || mstarve == SMAX || !p);
      pw = p && !fw;
      check("wb_stall", wb_stall, p && fw);
      check("llu_ready", llu_ready, !fl);
      if (mon_en) check("pending", pending, mpend);
      if (fw) begin
        e = mfifo.pop_front();
        mpend[e.rd] = 1'b0;
        if (e.rd != 0) begin
          e.due = cyc + 1;
          exp_q.push_back(e);
        end
      end else if (pw && wb_rd != 0) begin
        e.rd = wb_rd; e.data = wb_data; e.due = cyc + 1;
        exp_q.push_back(e);
      end
      if (fw || !f) mstarve = 0;
      else if (mstarve < SMAX) mstarve++;
      if (iss_valid) mpend[iss_rd] = 1'b1;
      mpend[0] = 1'b0;
      if (llu_valid && !fl) begin
        e.rd = llu_rd; e.data = llu_data; e.due = 0;
        mfifo.push_back(e);
      end
      last_stall = p && fw;
      last_llu_acc = llu_valid && !fl;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; iss_valid = 0; llu_valid = 0;
  endtask

  // Write-port monitor: each edge either retires the due expected write or must be idle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (mon_en) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          check("rf_we", rf_we, 1);
          check("rf_waddr", rf_waddr, exp_q[0].rd);
          check("rf_wdata", rf_wdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end else begin
          check("rf_we_idle", rf_we, 0);
        end
      end
    end
  end

  initial begin
    int stall_at;
    // Reset with an LLU result waiting.
    rst = 1; llu_valid = 1; llu_rd = 5'd4; llu_data = 32'h44;
    step(); step();
    check("reset_rf_we", rf_we, 0);
    check("reset_rf_waddr", rf_waddr, 0);
    check("reset_rf_wdata", rf_wdata, 0);
    check("reset_pending", pending, 0);
    mon_en = 1;
    rst = 0; idle();
    step();

    // Pipeline only, then rd=0.
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step();
    wb_rd = 5'd0; wb_data = 32'h1111;
    step();
    idle(); step();

    // LLU on an idle port.
    iss_valid = 1; iss_rd = 5'd7;
    step();
    iss_valid = 0;
    check("pend7_set", pending[7], 1);
    llu_valid = 1; llu_rd = 5'd7; llu_data = 32'h12;
    step();
    llu_valid = 0;
    step(); step();
    check("pend7_clear", pending[7], 0);

    // Starvation: one queued entry against a continuous pipeline.
    llu_valid = 1; llu_rd = 5'd3; llu_data = 32'hCAFE;
    step();
    llu_valid = 0;
    stall_at = -1;
    for (int i = 0; i < 8; i++) begin
      wb_valid = 1;
      if (!last_stall) begin wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom; end
      step();
      if (dut_stall && stall_at < 0) stall_at = i;
    end
    check("starve_stall_cycle", stall_at, 4);
    idle(); step();

    // Full FIFO takes priority over a streaming pipeline.
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1;
      if (!last_stall) begin wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom; end
      llu_valid = (i < 2);
      llu_rd = 5'(10 + i); llu_data = 32'hA0 + i;
      step();
    end
    idle(); step(); step();

    // Same-cycle reissue of a popping destination.
    iss_valid = 1; iss_rd = 5'd9;
    step();
    iss_valid = 0; llu_valid = 1; llu_rd = 5'd9; llu_data = 32'h99;
    step();
    llu_valid = 0; iss_valid = 1; iss_rd = 5'd9;
    step();
    iss_valid = 0;
    check("pend9_race", pending[9], 1);

    // Reset mid-stream with queued entries.
    wb_valid = 1; wb_rd = 5'd2; wb_data = 32'h22;
    llu_valid = 1; llu_rd = 5'd6; llu_data = 32'h66;
    step();
    llu_rd = 5'd8; llu_data = 32'h88;
    step();
    rst = 1; step();
    rst = 0; idle();
    check("midreset_pending", pending, 0);
    check("midreset_rf_we", rf_we, 0);
    step(); step();

    // Random traffic with handshake-respecting drivers.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!last_stall) begin
        wb_valid = ($urandom_range(0, 9) < 6);
        wb_rd = 5'($urandom);
        wb_data = $urandom;
      end
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_rd = 5'($urandom);
      if (!(llu_valid && !last_llu_acc)) begin
        llu_valid = ($urandom_range(0, 9) < 4);
        llu_rd = 5'($urandom);
        llu_data = $urandom;
      end
      step();
    end
    rst = 0; idle();
    for (int i = 0; i < 8; i++) step();
    check("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back result and a long-latency unit (LLU: multi-cycle mul/div, late loads).
- LLU results are buffered in a small FIFO.
- A pending-destination scoreboard is kept for the hazard unit.
- Sits after the write-back data mux, directly in front of the register file write port.

Parameters:
DATA_W, 32, data width of write-back and LLU results
ADDR_W, 5, register address width
FIFO_DEPTH, 2, LLU result buffer entries (power of 2, >=2)
STARVE_MAX, 4, max consecutive cycles a non-empty FIFO may lose arbitration

Ports:
i_clk  in  1  clock; single clock domain
i_rst  in  1  reset, synchronous, active-high
i_wb_valid  in  1  pipeline write-back requests a register write
i_wb_rd  in  ADDR_W  pipeline destination register
i_wb_data  in  DATA_W  pipeline write-back data (write-back mux output)
o_wb_stall  out  1  pipeline must hold its write-back request this cycle
i_iss_valid  in  1  LLU operation issued this cycle
i_iss_rd  in  ADDR_W  destination of the issued LLU operation
i_llu_valid  in  1  LLU result valid
i_llu_rd  in  ADDR_W  LLU result destination
i_llu_data  in  DATA_W  LLU result data
o_llu_ready  out  1  FIFO can accept an LLU result
o_rf_we  out  1  register file write enable (registered)
o_rf_waddr  out  ADDR_W  register file write address (registered)
o_rf_wdata  out  DATA_W  register file write data (registered)
o_pending  out  2**ADDR_W  scoreboard bitmap; bit r=1 means LLU write to xr outstanding

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Reset values: FIFO empty, starve counter 0, o_pending all 0, o_rf_we 0, o_rf_waddr 0, o_rf_wdata 0.
  - While i_rst=1: o_llu_ready=0 and o_wb_stall=0.
  - Asserting reset mid-operation discards FIFO contents and pending bits.
- LLU push:
  - o_llu_ready = !full (combinational, when not in reset).
  - Push occurs at the edge when i_llu_valid && o_llu_ready.
  - LLU holds rd/data stable while valid && !ready.
- Arbitration (combinational, each cycle):
  - Candidates: P = i_wb_valid; F = FIFO non-empty.
  - FIFO wins if F && (full || starve_cnt == STARVE_MAX || !P). Otherwise the pipeline wins if P.
  - o_wb_stall = P && FIFO wins.
  - The pipeline request is consumed whenever P && !o_wb_stall.
- Write port:
  - The winner in cycle N appears on o_rf_we/waddr/wdata in cycle N+1 (one-cycle latency).
  - o_rf_we=0 when no winner.
  - A winner with rd==0 is consumed (FIFO popped / pipeline not stalled) but produces o_rf_we=0.
- Starve counter:
  - +1 per cycle when F && pipeline wins, saturating at STARVE_MAX.
  - Cleared on any FIFO pop or when FIFO empty.
- FIFO:
  - Circular read/write pointers with wrap bit. Full = FIFO_DEPTH entries.
  - Push and pop may occur in the same cycle when not full; count is then unchanged.
  - A push into an empty FIFO is not eligible for arbitration until the next cycle (no bypass).
- Scoreboard:
  - i_iss_valid sets pending[i_iss_rd] at the edge.
  - FIFO pop clears pending[head.rd].
  - Simultaneous set and clear of the same rd: set wins.
  - pending[0] is constant 0.
  - Pipeline writes do not touch the scoreboard. WAW/RAW avoidance against o_pending is the hazard unit's job; this block never reorders writes from the same source.

Test Plan:
- Reset check: hold i_rst 2 cycles with i_llu_valid=1 -> o_llu_ready=0, o_rf_we=0, o_pending=0. Release -> o_llu_ready=1 next cycle.
- Pipeline-only: i_wb_valid=1, rd=5, data=0xDEADBEEF, FIFO empty -> o_wb_stall=0. Next cycle o_rf_we=1, waddr=5, wdata=0xDEADBEEF. Repeat with rd=0 -> o_rf_we=0, no stall.
- LLU idle port: issue rd=7 -> o_pending[7]=1. LLU returns rd=7, data=0x12 with pipeline idle -> write appears 2 cycles after push (push edge, arbitration cycle), and o_pending[7] clears.
- Starvation: FIFO holds 1 entry, i_wb_valid=1 continuously -> pipeline wins 4 cycles, then o_wb_stall=1 for exactly one cycle while the FIFO entry is written. Pipeline resumes next cycle.
- Full priority: fill FIFO (2 entries) while pipeline streams -> o_llu_ready=0, FIFO wins immediately, o_wb_stall=1. After pop, o_llu_ready=1.
- Scoreboard race: i_iss_valid with rd=9 in the same cycle a FIFO entry with rd=9 pops -> o_pending[9] remains 1. Then assert i_rst mid-stream -> FIFO empty, o_pending=0, o_rf_we=0.
